// File: rtl/nco_ctrl_pkg.sv
// Shared types and default widths for the NCO sweep controller.
package nco_ctrl_pkg;

    localparam int APR = 32;   // phase-increment width (matches NCO accumulator)
    localparam int DWW = 16;   // dwell-counter width
    localparam int NSW = 16;   // step-count width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Host/NCO-facing signal bundle of the sweep controller.
// master: host side (drives requests/config, NCO valid); slave: the controller.
interface nco_sweep_ctrl_if #(
    parameter int APR = nco_ctrl_pkg::APR,
    parameter int DWW = nco_ctrl_pkg::DWW,
    parameter int NSW = nco_ctrl_pkg::NSW
);
    logic           start;
    logic           abort;
    logic [APR-1:0] cfg_start_inc;
    logic [APR-1:0] cfg_step_inc;
    logic [NSW-1:0] cfg_num_steps;
    logic [DWW-1:0] cfg_dwell;
    logic           cfg_loop;
    logic           nco_out_valid;
    logic [APR-1:0] phi_inc_o;
    logic           nco_clken;
    logic           busy;
    logic           done;
    logic           step_strobe;
    logic [NSW-1:0] step_idx;

    modport master (
        output start, abort, cfg_start_inc, cfg_step_inc, cfg_num_steps,
               cfg_dwell, cfg_loop, nco_out_valid,
        input  phi_inc_o, nco_clken, busy, done, step_strobe, step_idx
    );

    modport slave (
        input  start, abort, cfg_start_inc, cfg_step_inc, cfg_num_steps,
               cfg_dwell, cfg_loop, nco_out_valid,
        output phi_inc_o, nco_clken, busy, done, step_strobe, step_idx
    );
endinterface

// File: rtl/nco_dwell_cnt.sv
// Dwell counter: latches the dwell length on load (0 is treated as 1),
// counts while enabled, wraps to 0 on its terminal count and flags it.
module nco_dwell_cnt #(
    parameter int DWW = nco_ctrl_pkg::DWW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [DWW-1:0] dwell,
    input  logic           clr,
    input  logic           en,
    output logic           tc
);
    logic [DWW-1:0] term_reg;
    logic [DWW-1:0] cnt_reg;

    assign tc = en && (cnt_reg == term_reg);

    // Terminal-count latch and the running count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            term_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            if (load) begin
                term_reg <= (dwell == '0) ? '0 : dwell - DWW'(1);
            end
            if (clr) begin
                cnt_reg <= '0;
            end else if (en) begin
                cnt_reg <= tc ? '0 : cnt_reg + DWW'(1);
            end
        end
    end
endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer in front of the sine NCO: waits out NCO warm-up,
// holds each phase increment for a dwell, steps it linearly, reports status.
// Build option: define NCO_SWEEP_BIDIR_EN for a triangle (up then down) sweep.
module nco_sweep_ctrl #(
    parameter int APR = nco_ctrl_pkg::APR,
    parameter int DWW = nco_ctrl_pkg::DWW,
    parameter int NSW = nco_ctrl_pkg::NSW
) (
    input  logic                clk,
    input  logic                reset,
    nco_sweep_ctrl_if.slave     bus
);
    import nco_ctrl_pkg::*;

    sweep_state_t   state_reg, state_next;
    logic [APR-1:0] phi_reg, phi_next;
    logic [APR-1:0] start_inc_reg, start_inc_next;
    logic [APR-1:0] step_inc_reg, step_inc_next;
    logic [NSW-1:0] idx_reg, idx_next;
    logic [NSW-1:0] last_idx_reg, last_idx_next;
    logic           loop_reg, loop_next;
    logic           strobe_reg, strobe_next;
    logic           done_reg, done_next;
    logic           busy_reg, clken_reg;
    logic           cnt_load, cnt_clr, cnt_en, cnt_tc;
`ifdef NCO_SWEEP_BIDIR_EN
    logic           down_reg, down_next;
`endif

    // The counter only runs in DWELL and is held at zero everywhere else,
    // so entering DWELL (from WARM) always starts a fresh dwell.
    assign cnt_en  = (state_reg == DWELL);
    assign cnt_clr = (state_reg != DWELL);

    nco_dwell_cnt #(.DWW(DWW)) u_dwell_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .dwell (bus.cfg_dwell),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    // Next-state and next-output logic; abort beats every other event.
    always_comb begin
        state_next     = state_reg;
        phi_next       = phi_reg;
        start_inc_next = start_inc_reg;
        step_inc_next  = step_inc_reg;
        idx_next       = idx_reg;
        last_idx_next  = last_idx_reg;
        loop_next      = loop_reg;
        strobe_next    = 1'b0;
        done_next      = 1'b0;
        cnt_load       = 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
        down_next      = down_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    start_inc_next = bus.cfg_start_inc;
                    step_inc_next  = bus.cfg_step_inc;
                    last_idx_next  = (bus.cfg_num_steps == '0) ? '0
                                     : bus.cfg_num_steps - NSW'(1);
                    loop_next      = bus.cfg_loop;
                    phi_next       = bus.cfg_start_inc;
                    idx_next       = '0;
                    cnt_load       = 1'b1;
                    state_next     = WARM;
`ifdef NCO_SWEEP_BIDIR_EN
                    down_next      = 1'b0;
`endif
                end
            end
            WARM: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (bus.nco_out_valid) begin
                    state_next = DWELL;
                end
            end
            DWELL: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (cnt_tc) begin
`ifdef NCO_SWEEP_BIDIR_EN
                    if (!down_reg) begin
                        if (idx_reg < last_idx_reg) begin
                            phi_next    = phi_reg + step_inc_reg;
                            idx_next    = idx_reg + NSW'(1);
                            strobe_next = 1'b1;
                        end else if (last_idx_reg != '0) begin
                            // Turn around without repeating the top frequency.
                            down_next   = 1'b1;
                            phi_next    = phi_reg - step_inc_reg;
                            idx_next    = idx_reg - NSW'(1);
                            strobe_next = 1'b1;
                        end else if (loop_reg) begin
                            phi_next    = start_inc_reg;
                            idx_next    = '0;
                            strobe_next = 1'b1;
                        end else begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        if (idx_reg != '0) begin
                            phi_next    = phi_reg - step_inc_reg;
                            idx_next    = idx_reg - NSW'(1);
                            strobe_next = 1'b1;
                        end else if (loop_reg) begin
                            // Bottom turnaround: climb again, start value not repeated.
                            down_next   = 1'b0;
                            phi_next    = phi_reg + step_inc_reg;
                            idx_next    = idx_reg + NSW'(1);
                            strobe_next = 1'b1;
                        end else begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end
                    end
`else
                    if (idx_reg < last_idx_reg) begin
                        phi_next    = phi_reg + step_inc_reg;
                        idx_next    = idx_reg + NSW'(1);
                        strobe_next = 1'b1;
                    end else if (loop_reg) begin
                        phi_next    = start_inc_reg;
                        idx_next    = '0;
                        strobe_next = 1'b1;
                    end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; busy/clken follow the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            phi_reg       <= '0;
            start_inc_reg <= '0;
            step_inc_reg  <= '0;
            idx_reg       <= '0;
            last_idx_reg  <= '0;
            loop_reg      <= 1'b0;
            strobe_reg    <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            clken_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phi_reg       <= phi_next;
            start_inc_reg <= start_inc_next;
            step_inc_reg  <= step_inc_next;
            idx_reg       <= idx_next;
            last_idx_reg  <= last_idx_next;
            loop_reg      <= loop_next;
            strobe_reg    <= strobe_next;
            done_reg      <= done_next;
            busy_reg      <= (state_next != IDLE);
            clken_reg     <= (state_next == WARM) || (state_next == DWELL);
        end
    end

`ifdef NCO_SWEEP_BIDIR_EN
    // Sweep direction: 0 climbing, 1 descending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            down_reg <= 1'b0;
        end else begin
            down_reg <= down_next;
        end
    end
`endif

    assign bus.phi_inc_o   = phi_reg;
    assign bus.nco_clken   = clken_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.step_strobe = strobe_reg;
    assign bus.step_idx    = idx_reg;
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: expected (phi, idx) pairs are queued
// when a sweep is launched and popped when the DUT loads or steps a frequency.
module tb_nco_sweep_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nco_sweep_ctrl_if #(.APR(32), .DWW(16), .NSW(16)) bus ();

    nco_sweep_ctrl #(.APR(32), .DWW(16), .NSW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] phi;
        logic [15:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   exp_gap  = 1;
    int   clken_cnt = 0;
    int   done_cnt  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_phi"}, 64'(bus.phi_inc_o), 64'(e.phi));
            check_eq({tag, "_idx"}, 64'(bus.step_idx), 64'(e.idx));
        end
    endtask

    // Monitor: frequency loads (busy rising) and steps, dwell spacing, done count.
    initial begin : monitor
        logic busy_q = 1'b0;
        bit   have_strobe = 1'b0;
        int   cyc = 0;
        int   last_strobe = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                busy_q      = 1'b0;
                have_strobe = 1'b0;
            end else begin
                if (bus.busy && !busy_q) begin
                    clken_cnt   = 0;
                    have_strobe = 1'b0;
                    $display("load: phi=0x%08h idx=%0d", bus.phi_inc_o, bus.step_idx);
                    pop_compare("load");
                end
                if (bus.nco_clken) clken_cnt++;
                if (bus.step_strobe) begin
                    $display("step: phi=0x%08h idx=%0d", bus.phi_inc_o, bus.step_idx);
                    pop_compare("step");
                    if (have_strobe) check_eq("strobe_gap", 64'(cyc - last_strobe), 64'(exp_gap));
                    have_strobe = 1'b1;
                    last_strobe = cyc;
                end
                if (bus.done) done_cnt++;
                busy_q = bus.busy;
            end
        end
    end

    task automatic push_sweep(input logic [31:0] si, input logic [31:0] ss,
                              input logic [15:0] ns, output int nfreq);
        int n;
        exp_t e;
        n = (ns == 16'd0) ? 1 : int'(ns);
        nfreq = 0;
        for (int i = 0; i < n; i++) begin
            e.phi = si + ss * 32'(i);
            e.idx = 16'(i);
            exp_q.push_back(e);
            nfreq++;
        end
`ifdef NCO_SWEEP_BIDIR_EN
        for (int i = n - 2; i >= 0; i--) begin
            e.phi = si + ss * 32'(i);
            e.idx = 16'(i);
            exp_q.push_back(e);
            nfreq++;
        end
`endif
    endtask

    task automatic launch(input logic [31:0] si, input logic [31:0] ss,
                          input logic [15:0] ns, input logic [15:0] dw, input logic lp);
        bus.cfg_start_inc = si;
        bus.cfg_step_inc  = ss;
        bus.cfg_num_steps = ns;
        bus.cfg_dwell     = dw;
        bus.cfg_loop      = lp;
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start         = 1'b0;
        // Config is latched on start; scramble it to prove later changes are ignored.
        bus.cfg_start_inc = $urandom;
        bus.cfg_step_inc  = $urandom;
        bus.cfg_num_steps = 16'($urandom_range(1, 9));
        bus.cfg_dwell     = 16'($urandom_range(1, 9));
        bus.cfg_loop      = 1'b1;
        check_eq("start_busy", 64'(bus.busy), 64'(1));
        check_eq("start_clken", 64'(bus.nco_clken), 64'(1));
    endtask

    task automatic run_sweep(input logic [31:0] si, input logic [31:0] ss,
                             input logic [15:0] ns, input logic [15:0] dw,
                             input int warm_lo, input bit repulse);
        int nfreq;
        int done0;
        bit seen;
        push_sweep(si, ss, ns, nfreq);
        exp_gap = (dw == 16'd0) ? 1 : int'(dw);
        done0 = done_cnt;
        launch(si, ss, ns, dw, 1'b0);
        repeat (warm_lo) @(negedge clk);
        bus.nco_out_valid = 1'b1;
        if (repulse) begin
            @(negedge clk);
            bus.cfg_start_inc = 32'hDEAD_0000;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) check_eq("done_timeout", 64'(0), 64'(1));
        check_eq("done_clken", 64'(bus.nco_clken), 64'(0));
        @(negedge clk);
        bus.nco_out_valid = 1'b0;
        check_eq("after_done", 64'(bus.done), 64'(0));
        check_eq("after_busy", 64'(bus.busy), 64'(0));
        check_eq("after_clken", 64'(bus.nco_clken), 64'(0));
        check_eq("done_pulses", 64'(done_cnt - done0), 64'(1));
        check_eq("hold_cycles", 64'(clken_cnt), 64'(warm_lo + 1 + nfreq * exp_gap));
        check_eq("sb_left", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        $display("sweep start=0x%08h step=0x%0h steps=%0d dwell=%0d finished", si, ss, ns, dw);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int done0;
        bit seen;
        exp_t e;
        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.cfg_start_inc = '0;
        bus.cfg_step_inc  = '0;
        bus.cfg_num_steps = '0;
        bus.cfg_dwell     = '0;
        bus.cfg_loop      = 1'b0;
        bus.nco_out_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_phi", 64'(bus.phi_inc_o), 64'(0));
        check_eq("rst_busy", 64'(bus.busy), 64'(0));
        check_eq("rst_clken", 64'(bus.nco_clken), 64'(0));
        check_eq("rst_done", 64'(bus.done), 64'(0));
        check_eq("rst_strobe", 64'(bus.step_strobe), 64'(0));
        check_eq("rst_idx", 64'(bus.step_idx), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Basic sweep with a 12-cycle warm-up.
        run_sweep(32'h100, 32'h10, 16'd3, 16'd4, 12, 1'b0);
        // Wrap-around: second value must be 0x00000008.
        run_sweep(32'hFFFF_FFF8, 32'h10, 16'd2, 16'd2, 1, 1'b0);
        // Degenerate config: 0 steps, 0 dwell.
        run_sweep(32'h1234, 32'h5, 16'd0, 16'd0, 0, 1'b0);
        // Start re-pulsed while busy must be ignored.
        run_sweep(32'h4000, 32'h100, 16'd3, 16'd6, 2, 1'b1);

        // Start and abort together in IDLE: abort wins.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_eq("start_abort_busy", 64'(bus.busy), 64'(0));
        check_eq("start_abort_clken", 64'(bus.nco_clken), 64'(0));

        // Abort in the 2nd DWELL cycle of step 1.
        begin
            int nf;
            push_sweep(32'h2000, 32'h40, 16'd4, nf);
        end
        exp_gap = 5;
        done0 = done_cnt;
        launch(32'h2000, 32'h40, 16'd4, 16'd5, 1'b0);
        @(negedge clk);
        bus.nco_out_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.step_strobe) seen = 1'b1;
        end
        if (!seen) check_eq("abort_strobe_timeout", 64'(0), 64'(1));
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.nco_out_valid = 1'b0;
        check_eq("abort_busy", 64'(bus.busy), 64'(0));
        check_eq("abort_clken", 64'(bus.nco_clken), 64'(0));
        check_eq("abort_phi_hold", 64'(bus.phi_inc_o), 64'(32'h2040));
        repeat (5) @(negedge clk);
        check_eq("abort_no_done", 64'(done_cnt - done0), 64'(0));
        exp_q.delete();
        run_sweep(32'h300, 32'h20, 16'd2, 16'd3, 1, 1'b0);

        // Loop mode: A, A+s, A, A+s ... ; valid is pulsed once, so any WARM
        // re-entry would stall the sweep and starve the scoreboard.
        for (int i = 0; i < 8; i++) begin
            e.phi = (i % 2 == 0) ? 32'h800 : 32'h880;
            e.idx = 16'(i % 2);
            exp_q.push_back(e);
        end
        exp_gap = 3;
        launch(32'h800, 32'h80, 16'd2, 16'd3, 1'b1);
        @(negedge clk);
        bus.nco_out_valid = 1'b1;
        @(negedge clk);
        bus.nco_out_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (exp_q.size() <= 2) seen = 1'b1;
        end
        if (!seen) check_eq("loop_timeout", 64'(exp_q.size()), 64'(2));
        check_eq("loop_busy", 64'(bus.busy), 64'(1));

        // Reset mid-sweep: outputs return to zero immediately.
        reset = 1'b1;
        #1;
        check_eq("midrst_phi", 64'(bus.phi_inc_o), 64'(0));
        check_eq("midrst_busy", 64'(bus.busy), 64'(0));
        check_eq("midrst_clken", 64'(bus.nco_clken), 64'(0));
        check_eq("midrst_idx", 64'(bus.step_idx), 64'(0));
        check_eq("midrst_done", 64'(bus.done), 64'(0));
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
